execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute (EX) stage of the 5-stage RV32I pipeline, directly downstream of the ALU control decoder; consumes its 3-bit ALUControl.
- Contents: operand forwarding muxes, ALU, branch/jump resolution, and the EX/MEM pipeline register.
- EX/MEM register supports stall (hold) and flush (bubble insertion).
- Feeds the memory stage and returns the redirect (PCSrcE/PCTargetE) to fetch.

Parameters:
XLEN, 32, datapath width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-low reset
stall_m  in  1  hold EX/MEM register contents
flush_e  in  1  squash instruction currently in EX
ValidE  in  1  EX holds a real instruction
RegWriteE  in  1  register-file write enable
MemWriteE  in  1  data-memory write enable
ResultSrcE  in  2  writeback source select
BranchE  in  1  conditional branch (beq)
JumpE  in  1  jal
ALUSrcE  in  1  0: SrcB = forwarded RD2; 1: SrcB = ImmExtE
ALUControlE  in  3  ALU operation from decoder
RD1E  in  XLEN  register operand 1
RD2E  in  XLEN  register operand 2
ImmExtE  in  XLEN  sign-extended immediate
PCE  in  XLEN  instruction PC
PCPlus4E  in  XLEN  PC+4
RdE  in  5  destination register
ForwardAE  in  2  SrcA forward select
ForwardBE  in  2  SrcB forward select
ResultW  in  XLEN  writeback-stage result
PCSrcE  out  1  redirect fetch (combinational)
PCTargetE  out  XLEN  PCE + ImmExtE (combinational)
ValidM  out  1  registered
RegWriteM  out  1  registered
MemWriteM  out  1  registered
ResultSrcM  out  2  registered
ALUResultM  out  XLEN  registered
WriteDataM  out  XLEN  registered forwarded RD2
RdM  out  5  registered
PCPlus4M  out  XLEN  registered

Behaviour:
- Forwarding: select 00 → RDxE; 01 → ResultW; 10 → ALUResultM (this block's registered output); 11 → RDxE (reserved).
- SrcA = forwarded A. SrcB = ALUSrcE ? ImmExtE : forwarded B. WriteData = forwarded B, regardless of ALUSrcE.
- ALU operations, all results XLEN bits, modulo 2^XLEN (carry/overflow discarded):
  - 000 add
  - 001 sub (SrcA − SrcB)
  - 010 and
  - 011 or
  - 101 slt: signed, result 1 or 0, zero-extended
  - 100/110/111: result 0
- ZeroE = (ALU result == 0).
- PCTargetE = PCE + ImmExtE, computed unconditionally.
- PCSrcE = ValidE & ~flush_e & ~stall_m & ((BranchE & ZeroE) | JumpE). It asserts only in the cycle the instruction leaves EX, so a stalled branch redirects exactly once.
- EX/MEM register, per rising edge, priority order:
  1. rst=0: all registered outputs cleared to 0.
  2. stall_m=1: all registered outputs hold, including during flush_e.
  3. flush_e=1 or ValidE=0: bubble — ValidM, RegWriteM, MemWriteM = 0; ResultSrcM = 00; RdM = 0; data fields (ALUResultM, WriteDataM, PCPlus4M) are don't-care but implemented as 0.
  4. Otherwise: capture ValidE, RegWriteE, MemWriteE, ResultSrcE, ALU result, WriteData, RdE, PCPlus4E.
- Latency: one cycle EX→M. PCSrcE/PCTargetE have zero latency.
- Reset mid-operation: the in-flight M contents are discarded. PCSrcE remains combinational during reset; fetch ignores it while rst=0.
- Stall with ForwardAE/BE=10 sources the held ALUResultM.

Test Plan:
- Reset: rst=0 for 2 cycles, then rst=1 with no valid input → all M outputs 0; PCSrcE=0.
- ALU sweep (ALUSrcE=0, forward 00):
  - RD1=5, RD2=7: 000→12; 001→0xFFFFFFFE; 010→5; 011→7; 101→1.
  - RD1=0x80000000, RD2=1, op 101 → 1 (signed).
  - op 111 → 0.
  - Each result appears on ALUResultM one cycle later.
- Forwarding:
  - Cycle n: add x1 = 3+4.
  - Cycle n+1: ForwardAE=10, ImmExtE=10, ALUSrcE=1, op 000 → ALUResultM=17 at n+2.
  - ForwardBE=01, ResultW=9, ALUSrcE=1 → WriteDataM=9, not ImmExtE.
- Branch:
  - BranchE=1, RD1=RD2=0x20, op 001, PCE=0x100, Imm=0x40 → PCSrcE=1, PCTargetE=0x140.
  - Same with RD2=0x21 → PCSrcE=0.
  - JumpE=1 → PCSrcE=1 independent of ZeroE.
- Stall: hold stall_m=1 for 3 cycles with a taken branch in EX → M outputs unchanged and PCSrcE=0 throughout; PCSrcE=1 in exactly the first cycle after release.
- Flush: flush_e=1 with RegWriteE=1, MemWriteE=1, RdE=5 → next cycle ValidM=0, RegWriteM=0, MemWriteM=0, RdM=0; PCSrcE=0 even if JumpE=1.

Source files
------------

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//
// Execute (EX) stage of the 5-stage RV32I pipeline. It selects operands
// through the forwarding muxes, runs the ALU, resolves branches and jumps
// (returning the redirect to fetch), and holds the EX/MEM pipeline register.
//
// Ports:
//   clk, rst                 clock (rising edge) and synchronous active-low reset
//   stall_m                  hold the EX/MEM register
//   flush_e                  squash the instruction currently in EX
//   ValidE .. PCPlus4E       decoded instruction and operands from ID/EX
//   ForwardAE, ForwardBE     forwarding selects from the hazard unit
//   ResultW                  writeback-stage result for forwarding
//   PCSrcE, PCTargetE        combinational redirect back to fetch
//   ValidM .. PCPlus4M       registered EX/MEM outputs to the memory stage
// ---------------------------------------------------------------------------
module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_m,
    input  logic            flush_e,
    input  logic            ValidE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            ALUSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            ValidM,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] PCPlus4M
);

    // ALU operation encodings produced by the ALU control decoder
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } aluOp_t;

    logic [XLEN-1:0] forwardA;
    logic [XLEN-1:0] forwardB;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic [XLEN-1:0] aluResult;
    logic            zeroE;
    logic            bubble;

    // Forwarding muxes: pick the register-file value, the writeback result,
    // or this stage's own registered ALU result. The reserved select 11
    // falls back to the register-file value. When the EX/MEM register is
    // stalled, select 10 naturally sources the held ALUResultM.
    always_comb begin
        forwardA = RD1E;
        forwardB = RD2E;
        case (ForwardAE)
            2'b01:   forwardA = ResultW;
            2'b10:   forwardA = ALUResultM;
            default: forwardA = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   forwardB = ResultW;
            2'b10:   forwardB = ALUResultM;
            default: forwardB = RD2E;
        endcase
    end

    // Operand B is the immediate for I-type/store address math; the store
    // data path always carries the forwarded register value instead.
    assign srcA = forwardA;
    assign srcB = ALUSrcE ? ImmExtE : forwardB;

    // ALU: all arithmetic wraps modulo 2^XLEN. Unused encodings yield zero.
    // slt compares as two's-complement signed values.
    always_comb begin
        aluResult = '0;
        case (ALUControlE)
            ALU_ADD: aluResult = srcA + srcB;
            ALU_SUB: aluResult = srcA - srcB;
            ALU_AND: aluResult = srcA & srcB;
            ALU_OR:  aluResult = srcA | srcB;
            ALU_SLT: aluResult = ($signed(srcA) < $signed(srcB)) ?
                                 {{(XLEN-1){1'b0}}, 1'b1} : '0;
            default: aluResult = '0;
        endcase
    end

    assign zeroE = (aluResult == '0);

    // Branch target is computed every cycle; the redirect fires only when
    // the instruction actually leaves EX, so a stalled branch redirects once.
    assign PCTargetE = PCE + ImmExtE;
    assign PCSrcE    = ValidE & ~flush_e & ~stall_m & ((BranchE & zeroE) | JumpE);

    assign bubble = flush_e | ~ValidE;

    // EX/MEM pipeline register. Priority: reset clears everything, a stall
    // holds everything (even over a flush), a flush or empty slot inserts
    // a zeroed bubble, otherwise the EX results are captured.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ValidM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            ALUResultM <= '0;
            WriteDataM <= '0;
            RdM        <= 5'd0;
            PCPlus4M   <= '0;
        end else if (stall_m) begin
            ValidM     <= ValidM;
            RegWriteM  <= RegWriteM;
            MemWriteM  <= MemWriteM;
            ResultSrcM <= ResultSrcM;
            ALUResultM <= ALUResultM;
            WriteDataM <= WriteDataM;
            RdM        <= RdM;
            PCPlus4M   <= PCPlus4M;
        end else if (bubble) begin
            ValidM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            ALUResultM <= '0;
            WriteDataM <= '0;
            RdM        <= 5'd0;
            PCPlus4M   <= '0;
        end else begin
            ValidM     <= ValidE;
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            ALUResultM <= aluResult;
            WriteDataM <= forwardB;
            RdM        <= RdE;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
//
// Directed, self-checking bench for execute_stage. Each step drives the EX
// inputs, checks the combinational redirect against a reference model,
// pushes the expected EX/MEM contents to a scoreboard queue and pops/compares
// them one clock later.
// ---------------------------------------------------------------------------
module tb_execute_stage;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic            regWrite;
        logic            memWrite;
        logic [1:0]      resultSrc;
        logic [XLEN-1:0] aluResult;
        logic [XLEN-1:0] writeData;
        logic [4:0]      rd;
        logic [XLEN-1:0] pcPlus4;
    } mState_t;

    logic            clk;
    logic            rst;
    logic            stall_m;
    logic            flush_e;
    logic            ValidE;
    logic            RegWriteE;
    logic            MemWriteE;
    logic [1:0]      ResultSrcE;
    logic            BranchE;
    logic            JumpE;
    logic            ALUSrcE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [4:0]      RdE;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic [XLEN-1:0] ResultW;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            ValidM;
    logic            RegWriteM;
    logic            MemWriteM;
    logic [1:0]      ResultSrcM;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [4:0]      RdM;
    logic [XLEN-1:0] PCPlus4M;

    int      checks = 0;
    int      errors = 0;
    mState_t expQ[$];
    mState_t modelM = '0;

    execute_stage #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_m     (stall_m),
        .flush_e     (flush_e),
        .ValidE      (ValidE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .ResultSrcE  (ResultSrcE),
        .BranchE     (BranchE),
        .JumpE       (JumpE),
        .ALUSrcE     (ALUSrcE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .RdE         (RdE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .ResultW     (ResultW),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .ValidM      (ValidM),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .RdM         (RdM),
        .PCPlus4M    (PCPlus4M)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU, written from the operation table
    function automatic logic [XLEN-1:0] aluModel(input logic [2:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return (sa < sb) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    // Reference forwarding mux
    function automatic logic [XLEN-1:0] fwdModel(input logic [1:0] sel,
                                                 input logic [XLEN-1:0] regVal);
        case (sel)
            2'b01:   return ResultW;
            2'b10:   return modelM.aluResult;
            default: return regVal;
        endcase
    endfunction

    // Compare one observed value with its expected value and tally it
    task automatic checkValue(input string tag, input logic [XLEN-1:0] observed,
                              input logic [XLEN-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Pop the oldest expected EX/MEM state and compare with the DUT
    task automatic checkOutput(input string tag);
        mState_t observed;
        mState_t expected;
        observed = '{ValidM, RegWriteM, MemWriteM, ResultSrcM, ALUResultM,
                     WriteDataM, RdM, PCPlus4M};
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $error("[TB] FAIL %s observed %h expected <scoreboard empty>", tag, observed);
        end else begin
            expected = expQ.pop_front();
            assert (observed === expected) else begin
                errors++;
                $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
            end
        end
    endtask

    // Run one cycle with the inputs currently driven: check the redirect at
    // the falling edge, predict the next EX/MEM state, then check it after
    // the rising edge.
    task automatic applyStimulus(input string tag);
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] res;
        logic            expSrc;
        mState_t         nextM;
        @(negedge clk);
        a      = fwdModel(ForwardAE, RD1E);
        b      = fwdModel(ForwardBE, RD2E);
        res    = aluModel(ALUControlE, a, ALUSrcE ? ImmExtE : b);
        expSrc = ValidE & ~flush_e & ~stall_m & ((BranchE & (res == 0)) | JumpE);
        checkValue({tag, ".pcsrc"}, {31'd0, PCSrcE}, {31'd0, expSrc});
        checkValue({tag, ".pctarget"}, PCTargetE, PCE + ImmExtE);
        if (!rst)
            nextM = '0;
        else if (stall_m)
            nextM = modelM;
        else if (flush_e || !ValidE)
            nextM = '0;
        else
            nextM = '{ValidE, RegWriteE, MemWriteE, ResultSrcE, res, b, RdE, PCPlus4E};
        expQ.push_back(nextM);
        @(posedge clk);
        modelM = nextM;
        #1;
        checkOutput({tag, ".m"});
    endtask

    task automatic clearInputs();
        stall_m     = 1'b0;
        flush_e     = 1'b0;
        ValidE      = 1'b0;
        RegWriteE   = 1'b0;
        MemWriteE   = 1'b0;
        ResultSrcE  = 2'b00;
        BranchE     = 1'b0;
        JumpE       = 1'b0;
        ALUSrcE     = 1'b0;
        ALUControlE = 3'b000;
        RD1E        = '0;
        RD2E        = '0;
        ImmExtE     = '0;
        PCE         = '0;
        PCPlus4E    = '0;
        RdE         = 5'd0;
        ForwardAE   = 2'b00;
        ForwardBE   = 2'b00;
        ResultW     = '0;
    endtask

    // Directed test sequence
    initial begin
        logic [2:0] ops [5];
        ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};

        rst = 1'b0;
        clearInputs();

        // Reset for two cycles, then release with nothing valid
        applyStimulus("reset0");
        applyStimulus("reset1");
        rst = 1'b1;
        applyStimulus("idle");
        checkValue("idle.validm", {31'd0, ValidM}, 32'd0);
        checkValue("idle.aluresm", ALUResultM, 32'd0);

        // ALU sweep with register operands
        ValidE = 1'b1; RegWriteE = 1'b1; RdE = 5'd3;
        RD1E = 32'd5; RD2E = 32'd7; PCPlus4E = 32'h0000_0004;
        for (int i = 0; i < 5; i++) begin
            ALUControlE = ops[i];
            applyStimulus("aluSweep");
        end
        ALUControlE = 3'b101; RD1E = 32'h8000_0000; RD2E = 32'd1;
        applyStimulus("sltSigned");
        checkValue("sltSigned.res", ALUResultM, 32'd1);
        ALUControlE = 3'b111; RD1E = 32'd5; RD2E = 32'd7;
        applyStimulus("opUnused");
        checkValue("opUnused.res", ALUResultM, 32'd0);
        ALUControlE = 3'b001;
        applyStimulus("subWrap");
        checkValue("subWrap.res", ALUResultM, 32'hFFFF_FFFE);

        // Forwarding from ALUResultM into SrcA
        ALUControlE = 3'b000; RD1E = 32'd3; RD2E = 32'd4; RdE = 5'd1;
        applyStimulus("fwdProducer");
        ForwardAE = 2'b10; ALUSrcE = 1'b1; ImmExtE = 32'd10; RD1E = 32'd100;
        applyStimulus("fwdConsumer");
        checkValue("fwdConsumer.res", ALUResultM, 32'd17);

        // Store data takes forwarded ResultW, not the immediate
        ForwardAE = 2'b00; ForwardBE = 2'b01; ResultW = 32'd9; RD2E = 32'd55;
        MemWriteE = 1'b1; RegWriteE = 1'b0; ResultSrcE = 2'b01;
        applyStimulus("fwdStore");
        checkValue("fwdStore.wdata", WriteDataM, 32'd9);
        clearInputs();

        // Branch taken, branch not taken, jump regardless of zero
        ValidE = 1'b1; BranchE = 1'b1; ALUControlE = 3'b001;
        RD1E = 32'h20; RD2E = 32'h20; PCE = 32'h100; ImmExtE = 32'h40;
        PCPlus4E = 32'h104;
        #1;
        checkValue("beqTaken.pcsrc", {31'd0, PCSrcE}, 32'd1);
        checkValue("beqTaken.target", PCTargetE, 32'h140);
        applyStimulus("beqTaken");
        RD2E = 32'h21;
        #1;
        checkValue("beqNotTaken.pcsrc", {31'd0, PCSrcE}, 32'd0);
        applyStimulus("beqNotTaken");
        BranchE = 1'b0; JumpE = 1'b1; RegWriteE = 1'b1; RdE = 5'd1;
        #1;
        checkValue("jal.pcsrc", {31'd0, PCSrcE}, 32'd1);
        applyStimulus("jal");
        clearInputs();

        // Stall with a taken branch in EX: hold M, redirect once on release
        ValidE = 1'b1; BranchE = 1'b1; ALUControlE = 3'b001;
        RD1E = 32'h20; RD2E = 32'h20; PCE = 32'h200; ImmExtE = 32'h10;
        stall_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkValue("stall.pcsrc", {31'd0, PCSrcE}, 32'd0);
            applyStimulus("stall");
        end
        stall_m = 1'b0;
        #1;
        checkValue("release.pcsrc", {31'd0, PCSrcE}, 32'd1);
        applyStimulus("release");
        clearInputs();

        // Flush with a jump and write enables set
        ValidE = 1'b1; flush_e = 1'b1; JumpE = 1'b1; RegWriteE = 1'b1;
        MemWriteE = 1'b1; RdE = 5'd5; RD1E = 32'd1; RD2E = 32'd2;
        #1;
        checkValue("flush.pcsrc", {31'd0, PCSrcE}, 32'd0);
        applyStimulus("flush");
        checkValue("flush.rdm", {27'd0, RdM}, 32'd0);
        checkValue("flush.regwritem", {31'd0, RegWriteM}, 32'd0);

        // Reset in the middle of a stream discards the in-flight instruction
        flush_e = 1'b0; JumpE = 1'b0;
        applyStimulus("preReset");
        rst = 1'b0;
        applyStimulus("midReset");
        rst = 1'b1;
        clearInputs();
        applyStimulus("postReset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
